// File: rtl/rf_ctrl_pkg.sv
// Shared widths, the write-port request record and the starvation FSM states
// used by the register-file write-port scheduler.
package rf_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } starve_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that buffers load returns until the register-file
// write port is free. The head is only visible from the cycle after a push.
module wb_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output wb_req_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = do_push ? wr_q + PW'(1) : wr_q;
    rd_d  = do_pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the counters alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Owns the register-file write port: ALU writeback has priority, buffered load
// returns fill idle slots; tracks pending loads and raises decode hazards.
//   state | meaning
//   IDLE  | no buffered return blocked by the ALU
//   WAIT  | head blocked, counting consecutive blocked cycles
//   FORCE | wb_stall asserted, head gets the port this cycle
module rf_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_addr,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              ld_issue_valid,
  input  logic [REG_AW-1:0] ld_issue_addr,
  input  logic              ld_ret_valid,
  output logic              ld_ret_ready,
  input  logic [REG_AW-1:0] ld_ret_addr,
  input  logic [XLEN-1:0]   ld_ret_data,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              hazard_stall,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREG-1:0]   busy,
  output logic              err
);

  localparam int            CW       = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_MAX - 1);

  wb_req_t       head, push_req;
  logic          fifo_full, fifo_empty;
  logic          push, pop, blocked;
  logic [NREG-1:0] busy_q, busy_d;
  logic          err_q, err_d;
  starve_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          sel_valid;

  assign ld_ret_ready = !fifo_full;
  assign push         = ld_ret_valid && !fifo_full;
  assign push_req     = '{addr: ld_ret_addr, data: ld_ret_data};
  assign pop          = !alu_wb_valid && !fifo_empty;
  assign blocked      = alu_wb_valid && !fifo_empty;

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    sel_valid = 1'b0;
    rf_waddr  = alu_wb_addr;
    rf_wdata  = alu_wb_data;
    if (alu_wb_valid) begin
      sel_valid = 1'b1;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      rf_waddr  = head.addr;
      rf_wdata  = head.data;
    end
    // x0 writes are dropped, and nothing is written while held in reset.
    rf_we = rst_n && sel_valid && (rf_waddr != '0);
  end

  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head.addr] = 1'b0;
    if (ld_issue_valid && ld_issue_addr != '0) busy_d[ld_issue_addr] = 1'b1;
    busy_d[0] = 1'b0;

    err_d = err_q
          | (push && ld_ret_addr != '0 && !busy_q[ld_ret_addr])
          | (alu_wb_valid && alu_wb_addr != '0 && busy_q[alu_wb_addr])
          | (state_q == FORCE && alu_wb_valid);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
    unique case (state_q)
      IDLE, WAIT: begin
        if (blocked) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc >= CNT_LAST) ? FORCE : WAIT;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      FORCE: begin
        if (!alu_wb_valid) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= '0;
      err_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      err_q   <= err_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hazard_stall = busy_q[rs1_addr] | busy_q[rs2_addr] | busy_q[rd_addr];
  assign wb_stall     = (state_q == FORCE);
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed and randomized checks of rf_wb_scheduler against a queue-based
// reference model of the write port, scoreboard and starvation guard.
module tb_rf_wb_scheduler;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_addr;
  logic        ld_ret_valid;
  logic        ld_ret_ready;
  logic [4:0]  ld_ret_addr;
  logic [31:0] ld_ret_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        hazard_stall, wb_stall, rf_we, err;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.LQ_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_wb_valid   (alu_wb_valid),
    .alu_wb_addr    (alu_wb_addr),
    .alu_wb_data    (alu_wb_data),
    .ld_issue_valid (ld_issue_valid),
    .ld_issue_addr  (ld_issue_addr),
    .ld_ret_valid   (ld_ret_valid),
    .ld_ret_ready   (ld_ret_ready),
    .ld_ret_addr    (ld_ret_addr),
    .ld_ret_data    (ld_ret_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rd_addr        (rd_addr),
    .hazard_stall   (hazard_stall),
    .wb_stall       (wb_stall),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .busy           (busy),
    .err            (err)
  );

  // Reference model state: buffered returns as {addr,data}, pending-load bits,
  // sticky error, and the length of the current run of blocked cycles.
  logic [36:0] m_q[$];
  logic [31:0] m_busy;
  bit          m_err, m_stall, m_pushed;
  int          m_run;
  logic [4:0]  outst[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = 0;
    ld_issue_valid = 0; ld_issue_addr = 0;
    ld_ret_valid = 0; ld_ret_addr = 0; ld_ret_data = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
  endtask

  task automatic model_reset();
    m_q.delete(); outst.delete();
    m_busy = 0; m_err = 0; m_stall = 0; m_run = 0;
  endtask

  // One clock: check every output at the falling edge, then advance the model.
  task automatic cyc();
    logic [36:0] sel;
    bit sel_v, pop, push, exp_ready, exp_we, exp_haz, had_head;
    @(negedge clk);
    exp_ready = (m_q.size() < DEPTH);
    push      = ld_ret_valid && exp_ready;
    had_head  = (m_q.size() > 0);
    pop = 0; sel_v = 0; sel = '0;
    if (alu_wb_valid) begin
      sel = {alu_wb_addr, alu_wb_data}; sel_v = 1;
    end else if (had_head) begin
      sel = m_q[0]; sel_v = 1; pop = 1;
    end
    exp_we  = rst_n && sel_v && (sel[36:32] != 5'd0);
    exp_haz = m_busy[rs1_addr] | m_busy[rs2_addr] | m_busy[rd_addr];
    chk("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(sel[36:32]));
      chk("rf_wdata", rf_wdata, sel[31:0]);
    end
    chk("ld_ret_ready", 32'(ld_ret_ready), 32'(exp_ready));
    chk("hazard_stall", 32'(hazard_stall), 32'(exp_haz));
    chk("wb_stall", 32'(wb_stall), 32'(m_stall));
    chk("busy", busy, m_busy);
    chk("err", 32'(err), 32'(m_err));
    @(posedge clk);
    m_pushed = 0;
    if (!rst_n) begin
      m_q.delete(); m_busy = 0; m_err = 0; m_stall = 0; m_run = 0;
    end else begin
      if (push && ld_ret_addr != 0 && !m_busy[ld_ret_addr]) m_err = 1;
      if (alu_wb_valid && alu_wb_addr != 0 && m_busy[alu_wb_addr]) m_err = 1;
      if (m_stall && alu_wb_valid) m_err = 1;
      if (pop) begin
        m_busy[sel[36:32]] = 1'b0;
        void'(m_q.pop_front());
      end
      if (ld_issue_valid && ld_issue_addr != 0) m_busy[ld_issue_addr] = 1'b1;
      if (push) begin
        m_q.push_back({ld_ret_addr, ld_ret_data});
        m_pushed = 1;
      end
      if (m_stall) begin
        if (!alu_wb_valid) begin m_stall = 0; m_run = 0; end
      end else if (alu_wb_valid && had_head) begin
        m_run++;
        if (m_run >= SMAX - 1) m_stall = 1;
      end else begin
        m_run = 0;
      end
    end
    #1;
  endtask

  task automatic issue(input int r);
    ld_issue_valid = 1; ld_issue_addr = 5'(r);
    cyc();
    ld_issue_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; cyc(); rst_n = 1; cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    idle_inputs();
    model_reset();
    rst_n = 0;
    #1;
    cyc(); cyc();
    rst_n = 1;
    cyc();
    chk("reset_busy", busy, 32'h0);
    chk("reset_ready", 32'(ld_ret_ready), 32'h1);
    chk("reset_wb_stall", 32'(wb_stall), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    // Basic load to x5
    issue(5);
    chk("basic_busy5", 32'(busy[5]), 32'h1);
    rs1_addr = 5; #1;
    chk("basic_hazard", 32'(hazard_stall), 32'h1);
    ld_ret_valid = 1; ld_ret_addr = 5; ld_ret_data = 32'hDEADBEEF;
    cyc();
    ld_ret_valid = 0; #1;
    chk("basic_we", 32'(rf_we), 32'h1);
    chk("basic_waddr", 32'(rf_waddr), 32'd5);
    chk("basic_wdata", rf_wdata, 32'hDEADBEEF);
    cyc();
    chk("basic_busy5_clr", 32'(busy[5]), 32'h0);
    chk("basic_hazard_clr", 32'(hazard_stall), 32'h0);
    rs1_addr = 0;

    // ALU priority over a buffered return
    issue(7);
    ld_ret_valid = 1; ld_ret_addr = 7; ld_ret_data = 32'h11;
    cyc();
    ld_ret_valid = 0;
    for (int k = 0; k < 2; k++) begin
      alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = $urandom; #1;
      chk("prio_alu_waddr", 32'(rf_waddr), 32'd3);
      cyc();
    end
    alu_wb_valid = 0; #1;
    chk("prio_ld_waddr", 32'(rf_waddr), 32'd7);
    chk("prio_ld_wdata", rf_wdata, 32'h11);
    cyc();

    // Starvation: head blocked by continuous ALU traffic
    issue(9);
    alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = 32'h1;
    ld_ret_valid = 1; ld_ret_addr = 9; ld_ret_data = 32'h55;
    cyc();
    ld_ret_valid = 0;
    for (int k = 0; k < SMAX - 1; k++) begin
      chk("starve_no_stall_yet", 32'(wb_stall), 32'h0);
      cyc();
    end
    chk("starve_stall", 32'(wb_stall), 32'h1);
    alu_wb_valid = 0; #1;
    chk("starve_waddr", 32'(rf_waddr), 32'd9);
    chk("starve_wdata", rf_wdata, 32'h55);
    cyc();
    chk("starve_release", 32'(wb_stall), 32'h0);

    // Full FIFO with a third return held off
    issue(10); issue(11); issue(13);
    alu_wb_valid = 1; alu_wb_addr = 3;
    ld_ret_valid = 1; ld_ret_addr = 10; ld_ret_data = 32'hA0A0;
    cyc();
    ld_ret_addr = 11; ld_ret_data = 32'hB1B1;
    cyc();
    chk("full_ready", 32'(ld_ret_ready), 32'h0);
    ld_ret_addr = 13; ld_ret_data = 32'hD3D3;
    m_pushed = 0;
    for (int k = 0; k < 10 && !m_pushed; k++) begin
      alu_wb_valid = !m_stall;
      cyc();
    end
    if (!m_pushed) begin
      miscompares++;
      $error("FAIL full_push_timeout: observed no accept expected accept");
    end
    ld_ret_valid = 0; alu_wb_valid = 0;
    for (int k = 0; k < 4; k++) cyc();
    chk("full_drained_busy", busy & 32'h2C00, 32'h0);

    // Boundaries
    ld_ret_valid = 1; ld_ret_addr = 0; ld_ret_data = 32'h77;
    cyc();
    ld_ret_valid = 0;
    cyc();
    chk("x0_err", 32'(err), 32'h0);
    ld_ret_valid = 1; ld_ret_addr = 12; ld_ret_data = 32'h12;
    cyc();
    ld_ret_valid = 0;
    chk("nonbusy_err", 32'(err), 32'h1);
    cyc(); cyc();
    chk("err_sticky", 32'(err), 32'h1);
    issue(4);
    ld_ret_valid = 1; ld_ret_addr = 4; ld_ret_data = 32'h44;
    cyc();
    ld_ret_valid = 0;
    issue(4);
    chk("set_wins_busy4", 32'(busy[4]), 32'h1);
    ld_ret_valid = 1; ld_ret_addr = 4; ld_ret_data = 32'h45;
    cyc();
    ld_ret_valid = 0;
    cyc();

    // Reset mid-operation
    do_reset();
    issue(5); issue(8);
    alu_wb_valid = 1; alu_wb_addr = 3;
    ld_ret_valid = 1; ld_ret_addr = 5; ld_ret_data = 32'h5;
    cyc();
    ld_ret_addr = 8; ld_ret_data = 32'h8;
    cyc();
    ld_ret_valid = 0;
    chk("pre_reset_busy", busy, 32'h0000_0120);
    chk("pre_reset_ready", 32'(ld_ret_ready), 32'h0);
    alu_wb_valid = 0; rst_n = 0; #1;
    chk("reset_no_we", 32'(rf_we), 32'h0);
    cyc();
    rst_n = 1;
    chk("mid_reset_busy", busy, 32'h0);
    chk("mid_reset_ready", 32'(ld_ret_ready), 32'h1);
    chk("mid_reset_wb_stall", 32'(wb_stall), 32'h0);
    chk("mid_reset_err", 32'(err), 32'h0);
    cyc();

    // Randomized traffic with a protocol-respecting pipeline and memory
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      if (outst.size() > 0 && $urandom_range(0, 1) == 1) begin
        ld_ret_valid = 1; ld_ret_addr = outst[0]; ld_ret_data = $urandom;
      end
      r = $urandom_range(1, 31);
      if ($urandom_range(0, 2) == 0 && !m_busy[r]) begin
        ld_issue_valid = 1; ld_issue_addr = 5'(r);
        outst.push_back(5'(r));
      end
      if (!m_stall && $urandom_range(0, 9) < 6) begin
        alu_wb_valid = 1;
        r = $urandom_range(0, 31);
        alu_wb_addr = m_busy[r] ? 5'd0 : 5'(r);
        alu_wb_data = $urandom;
      end
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      rd_addr  = 5'($urandom_range(0, 31));
      cyc();
      if (m_pushed) void'(outst.pop_front());
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
